// File: rtl/bit_count_unit.sv
// bit_count_unit: iterative bit counter. It computes the population count of
// a DATA_WIDTH operand. When BIT_COUNT_ZERO_MODES_EN is defined, it also
// computes count-leading-zeros and count-trailing-zeros. The unit examines
// CHUNK_WIDTH bits per enabled cycle and stops early once the answer is known.
//
// Build option:
//   BIT_COUNT_ZERO_MODES_EN  builds the CLZ/CTZ modes. If it is undefined,
//                            mode_i is ignored and every request is a popcount.
//
// Ports:
//   clk_i         rising-edge clock
//   rst_i         synchronous active-high reset; takes effect even when clk_en_i = 0
//   clk_en_i      clock enable; when low, all state and outputs are frozen
//   operand_i     word to count, sampled on acceptance
//   mode_i        00 popcount, 01 CLZ, 10 CTZ, 11 popcount
//   data_valid_i  request strobe; sampled only while idle_o = 1
//   data_valid_o  high for the DONE cycle; result_o was just updated
//   idle_o        unit can accept a request this cycle
//   result_o      last completed count; holds until the next completion
module bit_count_unit #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned CHUNK_WIDTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clk_en_i,
  input  logic [DATA_WIDTH-1:0]         operand_i,
  input  logic [1:0]                    mode_i,
  input  logic                          data_valid_i,
  output logic                          data_valid_o,
  output logic                          idle_o,
  output logic [$clog2(DATA_WIDTH):0]   result_o
);

  localparam int unsigned N_CHUNKS = DATA_WIDTH / CHUNK_WIDTH;
  localparam int unsigned RES_W    = $clog2(DATA_WIDTH) + 1;
  localparam int unsigned CNT_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(N_CHUNKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_e;

  state_e                  state_q;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [RES_W-1:0]        acc_q, acc_d;
  logic [RES_W-1:0]        result_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    finish_c;
  logic [CHUNK_WIDTH-1:0]  lo_chunk;

  assign lo_chunk = data_q[CHUNK_WIDTH-1:0];

  // Number of ones in one chunk.
  function automatic logic [RES_W-1:0] chunk_ones(input logic [CHUNK_WIDTH-1:0] c);
    logic [RES_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(CHUNK_WIDTH); i++) n = n + RES_W'(c[i]);
    return n;
  endfunction

`ifdef BIT_COUNT_ZERO_MODES_EN
  localparam logic [1:0] MODE_CLZ = 2'b01;
  localparam logic [1:0] MODE_CTZ = 2'b10;

  logic [1:0]              mode_q;
  logic [CHUNK_WIDTH-1:0]  hi_chunk;

  assign hi_chunk = data_q[DATA_WIDTH-1 -: CHUNK_WIDTH];

  // Leading zeros in a chunk; an all-zero chunk gives CHUNK_WIDTH.
  function automatic logic [RES_W-1:0] chunk_lz(input logic [CHUNK_WIDTH-1:0] c);
    logic [RES_W-1:0] n;
    n = RES_W'(CHUNK_WIDTH);
    for (int i = 0; i < int'(CHUNK_WIDTH); i++)
      if (c[i]) n = RES_W'(int'(CHUNK_WIDTH) - 1 - i);
    return n;
  endfunction

  // Trailing zeros in a chunk; an all-zero chunk gives CHUNK_WIDTH.
  function automatic logic [RES_W-1:0] chunk_tz(input logic [CHUNK_WIDTH-1:0] c);
    logic [RES_W-1:0] n;
    n = RES_W'(CHUNK_WIDTH);
    for (int i = int'(CHUNK_WIDTH) - 1; i >= 0; i--)
      if (c[i]) n = RES_W'(i);
    return n;
  endfunction
`else
  logic unused_mode;
  assign unused_mode = ^mode_i;
`endif

  // One COUNT step: next data, next accumulator, and whether the answer is complete.
  always_comb begin
    data_d   = data_q >> CHUNK_WIDTH;
    acc_d    = acc_q + chunk_ones(lo_chunk);
    finish_c = (cnt_q == LAST_CHUNK) || (data_d == '0);
`ifdef BIT_COUNT_ZERO_MODES_EN
    if (mode_q == MODE_CLZ) begin
      data_d   = data_q << CHUNK_WIDTH;
      acc_d    = acc_q + chunk_lz(hi_chunk);
      finish_c = (cnt_q == LAST_CHUNK) || (hi_chunk != '0);
    end else if (mode_q == MODE_CTZ) begin
      data_d   = data_q >> CHUNK_WIDTH;
      acc_d    = acc_q + chunk_tz(lo_chunk);
      finish_c = (cnt_q == LAST_CHUNK) || (lo_chunk != '0);
    end
`endif
  end

  // State machine and datapath registers; reset overrides the clock enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
`ifdef BIT_COUNT_ZERO_MODES_EN
      mode_q   <= '0;
`endif
    end else if (clk_en_i) begin
      case (state_q)
        S_IDLE: begin
          if (data_valid_i) begin
            data_q  <= operand_i;
`ifdef BIT_COUNT_ZERO_MODES_EN
            mode_q  <= mode_i;
`endif
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= S_COUNT;
          end
        end
        S_COUNT: begin
          data_q <= data_d;
          acc_q  <= acc_d;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (finish_c) begin
            result_q <= acc_d;
            state_q  <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data_valid_o = (state_q == S_DONE);
  assign idle_o       = (state_q == S_IDLE);
  assign result_o     = result_q;

endmodule
